vga_pattern_gen: RTL
====================

Name: vga_pattern_gen

Overview:
- Parametrised successor to the fixed-640x480, fixed-solid-colour VGA path.
- Generates H/V timing for any resolution from parameters, with configurable sync polarity and colour depth.
- Produces one of four run-time-selectable test patterns.
- Sits between the pixel clock generator and the board VGA pins, in the pixel clock domain. Exports pixel coordinates and a data-enable signal for later framebuffer readers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of vgaHsOut (0 = active-low)
- VS_POL, 0, active level of vgaVsOut
- COLOR_W, 4, bits per colour channel
- CHECK_LOG2, 5, log2 of checkerboard square size in pixels

Ports:
- clkIn  in  1  pixel clock
- rstIn  in  1  asynchronous, active-low reset
- modeIn  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient
- colorIn  in  3*COLOR_W  solid colour {R,G,B}, used in mode 0
- vgaROut  out  COLOR_W  red
- vgaGOut  out  COLOR_W  green
- vgaBOut  out  COLOR_W  blue
- vgaHsOut  out  1  horizontal sync
- vgaVsOut  out  1  vertical sync
- activeOut  out  1  high while the output pixel is visible
- xOut  out  clog2(H_ACTIVE)  visible x of the output pixel; 0 when not active
- yOut  out  clog2(V_ACTIVE)  visible y of the output pixel; 0 when not active
- frameStartOut  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Horizontal counter hCnt counts 0..H_TOTAL-1, then wraps.
- Vertical counter vCnt increments only on hCnt wrap and wraps at V_TOTAL-1.
- Active region: hCnt < H_ACTIVE and vCnt < V_ACTIVE.
- HS asserted for hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- VS asserted for vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). VS edges therefore coincide with hCnt==0.
- All outputs are registered with 1 cycle latency from counter state and are mutually aligned.
- Reset (rstIn low, asynchronous):
  - counters, colour outputs, activeOut, xOut, yOut, frameStartOut = 0
  - vgaHsOut = ~HS_POL, vgaVsOut = ~VS_POL
  - active mode register = 0; latched colour = 0; frame counter = 0
- Reset asserted mid-frame aborts the frame immediately. The first clock after release outputs pixel (0,0) with frameStartOut=1.
- modeIn and colorIn are sampled only on the cycle where hCnt=H_TOTAL-1 and vCnt=V_TOTAL-1. A new selection takes effect at the next frame's first pixel, so a frame never changes pattern mid-frame.
- The first frame after reset uses mode 0 with colour 0 (black).
- Colour outside the active region is forced to 0 in all modes.
- Mode 0: latched colorIn.
- Mode 1: 8 vertical bars, each BAR_W = H_ACTIVE/8 wide (integer). Bar index = min(x/BAR_W, 7), so any remainder extends bar 7. Bar order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale channel value = all ones.
- Mode 2: white when x[CHECK_LOG2] XOR y[CHECK_LOG2] = 0, otherwise black.
- Mode 3:
  - R = x[COLOR_W+3:4], G = y[COLOR_W+3:4], each zero-extended if the coordinate is narrower
  - B = frameCnt[COLOR_W-1:0]
  - frameCnt is an 8-bit counter incremented at each frame start; it wraps 255->0 and is running in all modes.

Optional Feature:
- Macro: VGA_BORDER_EN.
- When defined: pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 output full white in every mode, overriding the pattern. Latency is unchanged.
- When undefined: no border logic; the pattern is output unmodified.

Decomposition:
- Package vga_pkg:
  - mode constants MODE_SOLID=0, MODE_BARS=1, MODE_CHECK=2, MODE_GRAD=3
  - 8-entry 3-bit bar colour table {R,G,B} (white=111 ... black=000)
  - clog2 helper function
- Sub-module vga_timing_gen: counters, sync decode, active, x/y and frame-start generation. Same timing parameters and clock/reset.
- The top level adds the mode latch, frame counter and pattern mux.

Test Plan:
- Sim parameters: H 16/2/3/3 (H_TOTAL=24), V 8/1/2/1 (V_TOTAL=12), HS_POL=VS_POL=0, COLOR_W=4, CHECK_LOG2=1.
- Timing: reset, run 2 frames -> frameStartOut period 288 cycles; vgaHsOut low for exactly 3 cycles starting 18 cycles after each line start; vgaVsOut low for 48 cycles; activeOut high 128 cycles per frame.
- Mode latch: modeIn=1 driven mid-frame 0 -> frame 0 stays black. Frame 1 bars: x=0..1 white (F,F,F), x=10..11 red (F,0,0), x=14..15 black.
- Checkerboard: mode 2 -> pixel (0,0)=white, (2,0)=black, (2,2)=white, all channels 0 during blanking.
- Gradient/frame counter: mode 3 -> B increments by 1 per frame and wraps F->0 after 16 frames; R=0 for x<16.
- Reset mid-frame: assert rstIn low at hCnt=7, vCnt=3 -> outputs take reset values asynchronously. Release -> next cycle frameStartOut=1, xOut=yOut=0, mode back to 0.
- VGA_BORDER_EN defined, mode 0, colorIn=000 -> row 0, row 7, column 0 and column 15 are white; pixel (5,4) is black.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared mode encodings, colour-bar table and width helper for the VGA pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } modeT;

  // {R,G,B} per bar, bar 0 in the low three bits: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

  function automatic logic [2:0] barColor(input logic [2:0] idx);
    return BAR_TABLE[idx*3 +: 3];
  endfunction

  // Never returns less than 1 so that derived port widths stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus registered sync, active, coordinate and frame-start outputs.
// The pix* / frameEnd outputs expose the current counter state for pattern logic.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int XW = clog2(H_ACTIVE),
  localparam int YW = clog2(V_ACTIVE)
) (
  input  logic          clkIn,
  input  logic          rstIn,
  output logic          hsOut,
  output logic          vsOut,
  output logic          activeOut,
  output logic [XW-1:0] xOut,
  output logic [YW-1:0] yOut,
  output logic          frameStartOut,
  output logic          pixActive,
  output logic [XW-1:0] pixX,
  output logic [YW-1:0] pixY,
  output logic          frameEnd
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = clog2(H_TOTAL);
  localparam int VW = clog2(V_TOTAL);

  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          hEnd;
  logic          vEnd;
  logic          hSyncOn;
  logic          vSyncOn;

  assign hEnd      = (int'(hCnt) == H_TOTAL - 1);
  assign vEnd      = (int'(vCnt) == V_TOTAL - 1);
  assign frameEnd  = hEnd && vEnd;
  assign pixActive = (int'(hCnt) < H_ACTIVE) && (int'(vCnt) < V_ACTIVE);
  assign pixX      = pixActive ? XW'(hCnt) : '0;
  assign pixY      = pixActive ? YW'(vCnt) : '0;
  assign hSyncOn   = (int'(hCnt) >= H_ACTIVE + H_FP) && (int'(hCnt) < H_ACTIVE + H_FP + H_SYNC);
  assign vSyncOn   = (int'(vCnt) >= V_ACTIVE + V_FP) && (int'(vCnt) < V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hEnd) begin
      hCnt <= '0;
      vCnt <= vEnd ? '0 : vCnt + VW'(1);
    end else begin
      hCnt <= hCnt + HW'(1);
    end
  end

  // Everything below lags the counters by one clock, matching the registered colour path.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      hsOut         <= ~HS_POL;
      vsOut         <= ~VS_POL;
      activeOut     <= 1'b0;
      xOut          <= '0;
      yOut          <= '0;
      frameStartOut <= 1'b0;
    end else begin
      hsOut         <= hSyncOn ? HS_POL : ~HS_POL;
      vsOut         <= vSyncOn ? VS_POL : ~VS_POL;
      activeOut     <= pixActive;
      xOut          <= pixX;
      yOut          <= pixY;
      frameStartOut <= (hCnt == '0) && (vCnt == '0);
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing plus four run-time selectable test patterns.
// Optional build macro VGA_BORDER_EN forces a one-pixel white frame around the visible area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  localparam int XW = clog2(H_ACTIVE),
  localparam int YW = clog2(V_ACTIVE)
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic [1:0]           modeIn,
  input  logic [3*COLOR_W-1:0] colorIn,
  output logic [COLOR_W-1:0]   vgaROut,
  output logic [COLOR_W-1:0]   vgaGOut,
  output logic [COLOR_W-1:0]   vgaBOut,
  output logic                 vgaHsOut,
  output logic                 vgaVsOut,
  output logic                 activeOut,
  output logic [XW-1:0]        xOut,
  output logic [YW-1:0]        yOut,
  output logic                 frameStartOut
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic                 pixActive;
  logic [XW-1:0]        pixX;
  logic [YW-1:0]        pixY;
  logic                 frameEnd;
  modeT                 modeReg;
  logic [3*COLOR_W-1:0] colorReg;
  logic [7:0]           frameCnt;
  int                   barRaw;
  logic [2:0]           barIdx;
  logic [2:0]           barBits;
  logic [3*COLOR_W-1:0] barFull;
  logic                 checkOdd;
  logic [3*COLOR_W-1:0] pixColor;
  logic [3*COLOR_W-1:0] rgbReg;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL)
  ) uTiming (
    .clkIn         (clkIn),
    .rstIn         (rstIn),
    .hsOut         (vgaHsOut),
    .vsOut         (vgaVsOut),
    .activeOut     (activeOut),
    .xOut          (xOut),
    .yOut          (yOut),
    .frameStartOut (frameStartOut),
    .pixActive     (pixActive),
    .pixX          (pixX),
    .pixY          (pixY),
    .frameEnd      (frameEnd)
  );

  // Selection and frame count change only at the last raster position, never mid-frame.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      modeReg  <= MODE_SOLID;
      colorReg <= '0;
      frameCnt <= '0;
    end else if (frameEnd) begin
      modeReg  <= modeT'(modeIn);
      colorReg <= colorIn;
      frameCnt <= frameCnt + 8'd1;
    end
  end

  // The last bar absorbs any remainder of H_ACTIVE / 8.
  always_comb begin
    barRaw = int'(pixX) / BAR_W;
    barIdx = (barRaw > 7) ? 3'd7 : 3'(barRaw);
  end

  assign barBits  = barColor(barIdx);
  assign checkOdd = 1'((int'(pixX) >> CHECK_LOG2) ^ (int'(pixY) >> CHECK_LOG2));

  for (genvar gi = 0; gi < 3; gi++) begin : gBarChan
    assign barFull[gi*COLOR_W +: COLOR_W] = {COLOR_W{barBits[gi]}};
  end

`ifdef VGA_BORDER_EN
  logic onBorder;
  assign onBorder = (pixX == '0) || (int'(pixX) == H_ACTIVE - 1) ||
                    (pixY == '0) || (int'(pixY) == V_ACTIVE - 1);
`endif

  always_comb begin
    pixColor = '0;
    case (modeReg)
      MODE_SOLID: pixColor = colorReg;
      MODE_BARS:  pixColor = barFull;
      MODE_CHECK: pixColor = checkOdd ? '0 : '1;
      MODE_GRAD:  pixColor = {COLOR_W'(int'(pixX) >> 4), COLOR_W'(int'(pixY) >> 4),
                              COLOR_W'(frameCnt)};
      default:    pixColor = '0;
    endcase
`ifdef VGA_BORDER_EN
    if (onBorder) pixColor = '1;
`endif
    if (!pixActive) pixColor = '0;
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) rgbReg <= '0;
    else        rgbReg <= pixColor;
  end

  assign vgaROut = rgbReg[3*COLOR_W-1 -: COLOR_W];
  assign vgaGOut = rgbReg[2*COLOR_W-1 -: COLOR_W];
  assign vgaBOut = rgbReg[COLOR_W-1:0];

endmodule
